gsim_host: RTL and testbench
============================

GSIM_HOST -- requirements
Module: gsim_host

Interface
REQ-001 Parameter TIMEOUT, default 2048, is the maximum number of cycles allowed in WAIT or RECV before the run aborts.
REQ-002 Parameter TOL, default 65536, is the largest accepted |residual| (Q16.16 units) for a pass.
REQ-003 Port clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  in  1  SHALL be an asynchronous, active-high reset.
REQ-005 Port start  in  1  is a one-cycle request to begin a run.
REQ-006 Port ld_en  in  1  is the b-memory write strobe.
REQ-007 Port ld_addr  in  4  is the b-memory write index (0 = b1).
REQ-008 Port ld_data  in  16  is the signed integer b value to write.
REQ-009 Port in_en  out  1  is the b-stream valid, driven to the solver.
REQ-010 Port b_out  out  16  is the b value streamed to the solver.
REQ-011 Port out_valid  in  1  is the result-beat valid from the solver.
REQ-012 Port x_in  in  32  is the signed Q16.16 solution beat from the solver.
REQ-013 Port busy  out  1  is high in every state except IDLE.
REQ-014 Port done  out  1  is a one-cycle end-of-run pulse.
REQ-015 Port pass  out  1  is the run verdict, valid from done until the next accepted start.
REQ-016 Port timeout  out  1  flags that the run aborted on timeout.
REQ-017 Port max_abs_res  out  40  is the largest |r_i| of the last checked run.
REQ-018 Port rd_addr  in  4  is the captured-x read index.
REQ-019 Port rd_data  out  32  is the combinational read of captured x[rd_addr].

Function
REQ-020 FSM states SHALL be IDLE, SEND, WAIT, RECV, CHECK and DONE.
- Unconditional: SEND->WAIT after 16 cycles; CHECK->DONE after 16 cycles; DONE->IDLE after one cycle.
REQ-021 In IDLE, start SHALL move the FSM to SEND, clear pass, timeout and max_abs_res, and zero the beat and timer counters; start SHALL be ignored in all other states.
REQ-022 In IDLE, ld_en SHALL write ld_data to b[ld_addr]; ld_en SHALL be ignored outside IDLE.
REQ-023 For a start accepted at edge T, in_en SHALL be high for exactly 16 consecutive cycles, beginning in the cycle after T.
- b_out SHALL present b1..b16 in order, one per cycle.
- Outside SEND, in_en = 0 and b_out = 0.
REQ-024 In WAIT and RECV, each cycle with out_valid = 1 SHALL store x_in as the next x_k, k = 1..16 in arrival order.
- Beats need not be contiguous.
- The 16th beat moves the FSM to CHECK.
- Beats arriving in IDLE, SEND, CHECK or DONE SHALL be dropped.
REQ-025 A timer SHALL count the cycles spent in WAIT plus RECV.
- When it reaches TIMEOUT before the 16th beat, the FSM SHALL go to DONE with timeout = 1 and pass = 0, and CHECK SHALL be skipped.
REQ-026 CHECK SHALL compute one residual per cycle, i = 1..16:
- r_i = 20x_i - 13(x_{i-1}+x_{i+1}) + 6(x_{i-2}+x_{i+2}) - (x_{i-3}+x_{i+3}) - (b_i<<16).
- Any index outside 1..16 contributes 0.
REQ-027 Residual arithmetic SHALL be 40-bit signed, with sign extension and no saturation or truncation.
REQ-028 max_abs_res SHALL update to max(max_abs_res, |r_i|) on each CHECK cycle.
REQ-029 In DONE: done = 1 and pass = (max_abs_res <= TOL); pass, timeout and max_abs_res SHALL hold until the next accepted start.
REQ-030 The x memory SHALL remain readable through rd_addr/rd_data in every state.

Reset
REQ-031 While reset is asserted, the FSM SHALL be IDLE and in_en, b_out, busy, done, pass, timeout and max_abs_res SHALL all be 0.
REQ-032 Reset SHALL clear all b and x entries to 0.
REQ-033 Reset asserted mid-run SHALL abort the run immediately (in_en drops in the same cycle); the first start after deassertion SHALL be accepted normally.

Verification
REQ-034 Scenario: all b = 0, start, solver model returns 16 beats of 0 after 70 cycles -> in_en high exactly 16 cycles with b_out = 0, done pulse, pass = 1, max_abs_res = 0.
REQ-035 Scenario: b1 = 20, others 0; model returns x1 = 0x00010000, others 0 -> r1 = 0, |r2| = 851968, max_abs_res = 851968, pass = 0, timeout = 0.
REQ-036 Scenario: b loaded 1..16, out_valid never asserted -> b_out = 1..16 during SEND, done exactly TIMEOUT cycles after entering WAIT, timeout = 1, pass = 0.
REQ-037 Scenario: 20 beats of 0x00000001..0x00000014 with gaps, plus start and ld_en pulsed while busy -> starts ignored, b unchanged, rd_addr 0..15 reads 0x00000001..0x00000010.
REQ-038 Scenario: reset pulsed during RECV after 5 beats -> busy, in_en and done low at once, all rd_data = 0; a new start then runs to a normal done.

Source files
------------

// File: rtl/gsim_host.sv
// Host-side harness for a 16-point banded solver: streams b, captures the x beats
// and checks the band residuals in Q16.16.
module gsim_host #(
  parameter int unsigned TIMEOUT = 2048,
  parameter int unsigned TOL     = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ld_en,
  input  logic [3:0]  ld_addr,
  input  logic [15:0] ld_data,
  output logic        in_en,
  output logic [15:0] b_out,
  input  logic        out_valid,
  input  logic [31:0] x_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [39:0] max_abs_res,
  input  logic [3:0]  rd_addr,
  output logic [31:0] rd_data
);

  localparam int unsigned NB = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned RW = 40;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, CHECK, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 in_en_d, busy_d, done_d, pass_d, timeout_d;
  logic [15:0]          b_out_d;
  logic [RW-1:0]        max_d;
  logic                 b_we, x_we;

  logic signed [15:0]   b_mem [NB];
  logic signed [31:0]   x_mem [NB];

  logic signed [RW-1:0] xw [7];
  logic signed [RW-1:0] bw;
  logic signed [RW-1:0] res;
  logic [RW-1:0]        abs_res;
  logic [RW-1:0]        max_next;

  assign rd_data = x_mem[rd_addr];

  // Band window around x_i; neighbours outside 1..16 read as zero.
  always_comb begin
    for (int j = 0; j < 7; j++) begin
      int k;
      k = int'(cnt_q) + j - 3;
      xw[j] = '0;
      if (k >= 0 && k < int'(NB)) xw[j] = RW'(x_mem[CW'(k)]);
    end
  end

  always_comb begin
    bw       = {{(RW-32){b_mem[cnt_q][15]}}, b_mem[cnt_q], 16'h0000};
    res      = 40'sd20 * xw[3] - 40'sd13 * (xw[2] + xw[4])
             + 40'sd6 * (xw[1] + xw[5]) - (xw[0] + xw[6]) - bw;
    abs_res  = res[RW-1] ? RW'(-res) : RW'(res);
    max_next = (abs_res > max_abs_res) ? abs_res : max_abs_res;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    in_en_d   = 1'b0;
    b_out_d   = '0;
    done_d    = 1'b0;
    pass_d    = pass;
    timeout_d = timeout;
    max_d     = max_abs_res;
    b_we      = 1'b0;
    x_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        b_we = ld_en;
        if (start) begin
          state_d   = SEND;
          cnt_d     = '0;
          timer_d   = '0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          max_d     = '0;
          in_en_d   = 1'b1;
          b_out_d   = b_mem[0];
        end
      end
      SEND: begin
        if (cnt_q == CW'(NB - 1)) begin
          state_d = WAIT;
          cnt_d   = '0;
          timer_d = '0;
        end else begin
          cnt_d   = CW'(cnt_q + 1'b1);
          in_en_d = 1'b1;
          b_out_d = b_mem[CW'(cnt_q + 1'b1)];
        end
      end
      WAIT, RECV: begin
        x_we = out_valid;
        if (out_valid) state_d = RECV;
        // A 16th beat landing on the expiry cycle still completes the run.
        if (out_valid && cnt_q == CW'(NB - 1)) begin
          state_d = CHECK;
          cnt_d   = '0;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          timer_d = TW'(timer_q + 1'b1);
          if (out_valid) cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      CHECK: begin
        max_d = max_next;
        if (cnt_q == CW'(NB - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = (max_next <= RW'(TOL));
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      timer_q     <= '0;
      in_en       <= 1'b0;
      b_out       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      max_abs_res <= '0;
      for (int i = 0; i < int'(NB); i++) begin
        b_mem[i] <= '0;
        x_mem[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      in_en       <= in_en_d;
      b_out       <= b_out_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      timeout     <= timeout_d;
      max_abs_res <= max_d;
      if (b_we) b_mem[ld_addr] <= ld_data;
      if (x_we) x_mem[cnt_q]   <= x_in;
    end
  end

endmodule

// File: tb/tb_gsim_host.sv
// Directed bench for gsim_host: a scripted solver stands in for the real one and
// every expected value comes from constants or the reference residual function.
module tb_gsim_host;

  localparam int unsigned TIMEOUT = 2048;
  localparam int unsigned TOL     = 65536;

  logic        clk = 1'b0;
  logic        reset, start, ld_en, out_valid;
  logic [3:0]  ld_addr, rd_addr;
  logic [15:0] ld_data, b_out;
  logic [31:0] x_in, rd_data;
  logic        in_en, busy, done, pass, timeout;
  logic [39:0] max_abs_res;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint tb_x [16];
  longint tb_b [16];

  gsim_host #(.TIMEOUT(TIMEOUT), .TOL(TOL)) dut (
    .clk(clk), .reset(reset), .start(start), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .in_en(in_en), .b_out(b_out), .out_valid(out_valid),
    .x_in(x_in), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .max_abs_res(max_abs_res), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_b(input int idx, input int val);
    ld_en   = 1'b1;
    ld_addr = 4'(idx);
    ld_data = 16'(val);
    step();
    ld_en   = 1'b0;
    tb_b[idx] = longint'(val);
  endtask

  // Start a run and follow the 16-cycle b stream; poke drives illegal requests mid-stream.
  task automatic run_send(input bit poke);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("in_en_send", 64'(in_en), 64'(1));
      check("b_out", 64'(b_out), 64'(16'(tb_b[i])));
      if (poke && i == 5) begin
        start = 1'b1; ld_en = 1'b1; ld_addr = 4'd3; ld_data = 16'd999;
      end
      step();
      start = 1'b0; ld_en = 1'b0;
    end
    check("in_en_after_send", 64'(in_en), 64'(0));
    check("b_out_after_send", 64'(b_out), 64'(0));
    check("busy_wait", 64'(busy), 64'(1));
  endtask

  task automatic beat(input logic [31:0] v);
    out_valid = 1'b1;
    x_in      = v;
    step();
    out_valid = 1'b0;
    x_in      = '0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
    check("done_seen", 64'(done), 64'(1));
  endtask

  function automatic longint xa(input int j);
    return (j >= 0 && j < 16) ? tb_x[j] : 64'sd0;
  endfunction

  function automatic longint ref_max();
    longint m, r;
    m = 0;
    for (int i = 0; i < 16; i++) begin
      r = 20 * xa(i) - 13 * (xa(i-1) + xa(i+1)) + 6 * (xa(i-2) + xa(i+2))
        - (xa(i-3) + xa(i+3)) - tb_b[i] * 65536;
      if (r < 0) r = -r;
      if (r > m) m = r;
    end
    return m;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c;
    longint exp_max;
    reset = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    out_valid = 1'b0; x_in = '0; rd_addr = '0;
    for (int i = 0; i < 16; i++) begin tb_x[i] = 0; tb_b[i] = 0; end
    step(); step();
    check("rst_in_en", 64'(in_en), 64'(0));
    check("rst_b_out", 64'(b_out), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_pass", 64'(pass), 64'(0));
    check("rst_timeout", 64'(timeout), 64'(0));
    check("rst_max", 64'(max_abs_res), 64'(0));
    check("rst_rd", 64'(rd_data), 64'(0));
    reset = 1'b0;
    step();

    // All-zero system, 16 zero beats after 70 cycles.
    run_send(1'b0);
    repeat (70) step();
    for (int k = 0; k < 16; k++) beat(32'h0);
    wait_done(100, c);
    check("check_latency", 64'(c), 64'(16));
    check("s1_pass", 64'(pass), 64'(1));
    check("s1_max", 64'(max_abs_res), 64'(0));
    check("s1_timeout", 64'(timeout), 64'(0));
    step();
    check("s1_done_pulse", 64'(done), 64'(0));
    check("s1_idle", 64'(busy), 64'(0));
    check("s1_pass_hold", 64'(pass), 64'(1));

    // b1 = 20 with x1 = 1.0: the -13 band term dominates.
    load_b(0, 20);
    run_send(1'b0);
    repeat (5) step();
    beat(32'h0001_0000);
    for (int k = 1; k < 16; k++) beat(32'h0);
    wait_done(100, c);
    check("s2_max", 64'(max_abs_res), 64'(851968));
    check("s2_pass", 64'(pass), 64'(0));
    check("s2_timeout", 64'(timeout), 64'(0));
    rd_addr = 4'd0; #1;
    check("s2_x1", 64'(rd_data), 64'(32'h0001_0000));
    step();

    // b = 1..16 with a silent solver.
    for (int i = 0; i < 16; i++) load_b(i, i + 1);
    run_send(1'b0);
    wait_done(int'(TIMEOUT) + 100, c);
    check("s3_timeout_cycles", 64'(c), 64'(TIMEOUT));
    check("s3_timeout", 64'(timeout), 64'(1));
    check("s3_pass", 64'(pass), 64'(0));
    check("s3_max", 64'(max_abs_res), 64'(0));
    step();
    check("s3_done_pulse", 64'(done), 64'(0));

    // 20 gapped beats with illegal start/ld_en while busy.
    run_send(1'b1);
    for (int k = 1; k <= 20; k++) begin
      beat(32'(k));
      if (k == 3) start = 1'b1;
      step();
      start = 1'b0;
      if (k == 3) check("s4_start_ignored", 64'(in_en), 64'(0));
    end
    for (int i = 0; i < 16; i++) tb_x[i] = longint'(i + 1);
    exp_max = ref_max();
    wait_done(100, c);
    check("s4_max", 64'(max_abs_res), 64'(exp_max));
    check("s4_pass", 64'(pass), 64'(exp_max <= longint'(TOL)));
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      check("s4_rd", 64'(rd_data), 64'(i + 1));
    end
    step();

    // Reset in RECV after 5 beats, then a clean run.
    run_send(1'b0);
    for (int k = 0; k < 5; k++) beat(32'h100 + 32'(k));
    reset = 1'b1; #1;
    check("s5_busy", 64'(busy), 64'(0));
    check("s5_in_en", 64'(in_en), 64'(0));
    check("s5_done", 64'(done), 64'(0));
    check("s5_max", 64'(max_abs_res), 64'(0));
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i); #1;
      check("s5_rd_zero", 64'(rd_data), 64'(0));
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin tb_b[i] = 0; tb_x[i] = 0; end
    step();
    run_send(1'b0);
    repeat (3) step();
    for (int k = 0; k < 16; k++) beat(32'h0);
    wait_done(100, c);
    check("s5_pass", 64'(pass), 64'(1));
    check("s5_timeout", 64'(timeout), 64'(0));
    check("s5_max_after", 64'(max_abs_res), 64'(0));
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
